bounce_generator: RTL and testbench



---
 rtl/bounce_generator.sv | 104 ++++++++++
 tb/tb_bounce_generator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: turns a clean clk-synchronous level into a noisy level
// with a pseudo-random glitch burst after every change, then settles to the clean level.
module bounce_generator #(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned MIN_HOLD      = 2,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       clean_in,
  output logic       noisy_output,
  output logic       busy,
  output logic [7:0] toggle_count
);

  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] WIN_INIT  = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_INIT = 16'(MIN_HOLD - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_BOUNCE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        target_q, target_d;
  logic        noisy_q, noisy_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] win_q, win_d;
  logic [15:0] hold_q, hold_d;
  logic        rnd;
  logic [7:0]  cnt_inc;

  // Galois LFSR free-runs every cycle so the pattern depends only on SEED and stimulus timing.
  assign rnd     = lfsr_q[0];
  assign lfsr_d  = (lfsr_q >> 1) ^ (rnd ? LFSR_TAPS : 16'h0000);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    noisy_d  = noisy_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    hold_d   = hold_q;

    if (!en) begin
      state_d  = S_IDLE;
      target_d = clean_in;
      noisy_d  = clean_in;
    end else if (clean_in != target_q) begin
      // Start or retarget: the first glitch is forced so the edge is always seen next cycle.
      state_d  = S_BOUNCE;
      target_d = clean_in;
      win_d    = WIN_INIT;
      hold_d   = HOLD_INIT;
      noisy_d  = ~noisy_q;
      cnt_d    = 8'd1;
    end else if (state_q == S_BOUNCE) begin
      if (win_q == 16'd0) begin
        state_d = S_IDLE;
        noisy_d = target_q;
        if (noisy_q != target_q) cnt_d = cnt_inc;
      end else begin
        win_d = win_q - 16'd1;
        if (hold_q != 16'd0) begin
          hold_d = hold_q - 16'd1;
        end else if (rnd) begin
          noisy_d = ~noisy_q;
          hold_d  = HOLD_INIT;
          cnt_d   = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      target_q <= 1'b0;
      noisy_q  <= 1'b0;
      cnt_q    <= 8'd0;
      lfsr_q   <= SEED_EFF;
      win_q    <= 16'd0;
      hold_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      noisy_q  <= noisy_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      win_q    <= win_d;
      hold_q   <= hold_d;
    end
  end

  assign noisy_output = noisy_q;
  assign busy         = (state_q == S_BOUNCE);
  assign toggle_count = cnt_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed self-checking bench for bounce_generator with default parameters.
module tb_bounce_generator;

  localparam int BOUNCE   = 16;
  localparam int MIN_HOLD = 2;
  localparam int NMAX     = 32;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       clean_in;
  logic       noisy_output;
  logic       busy;
  logic [7:0] toggle_count;

  int n_tests;
  int n_fail;

  logic       wave_n[NMAX];
  logic       wave_b[NMAX];
  logic [7:0] wave_c[NMAX];
  logic       ref_n[NMAX];

  bounce_generator #(
    .BOUNCE_CYCLES(16),
    .MIN_HOLD(2),
    .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .clean_in(clean_in),
    .noisy_output(noisy_output),
    .busy(busy),
    .toggle_count(toggle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic clean_lvl);
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    en       = 1'b1;
    clean_in = clean_lvl;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Records outputs after each of the next n edges; optionally changes clean_in after sample chg_idx.
  task automatic capture(input int n, input int chg_idx, input logic chg_val);
    for (int i = 0; i < n; i++) begin
      tick();
      wave_n[i] = noisy_output;
      wave_b[i] = busy;
      wave_c[i] = toggle_count;
      if (i == chg_idx) clean_in = chg_val;
    end
  endtask

  task automatic check_burst(input string name, input logic prev_level, input int start_idx,
                             input int busy_len, input logic final_lvl, input int n);
    int   blen;
    int   trans;
    int   viol;
    int   last_t;
    logic prev;
    logic settled;
    logic found;
    blen  = n;
    found = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!found && !wave_b[i]) begin
        blen  = i;
        found = 1'b1;
      end
    end
    n_tests++;
    if (blen !== busy_len) begin
      n_fail++;
      $display("FAIL %s_busy_len: got %0d expected %0d", name, blen, busy_len);
    end

    prev = (start_idx == 0) ? prev_level : wave_n[start_idx-1];
    n_tests++;
    if (wave_n[start_idx] !== ~prev) begin
      n_fail++;
      $display("FAIL %s_first_glitch: got %0b expected %0b", name, wave_n[start_idx], ~prev);
    end
    n_tests++;
    if (wave_c[start_idx] !== 8'd1) begin
      n_fail++;
      $display("FAIL %s_cnt_start: got %0d expected 1", name, wave_c[start_idx]);
    end

    trans  = 0;
    viol   = 0;
    last_t = -1;
    for (int i = start_idx; i < n; i++) begin
      if (wave_n[i] !== prev) begin
        trans++;
        if (last_t >= 0 && (i - last_t) < MIN_HOLD && i != busy_len) viol++;
        last_t = i;
        prev   = wave_n[i];
      end
    end
    n_tests++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL %s_spacing: got %0d violations expected 0", name, viol);
    end
    n_tests++;
    if (wave_c[n-1] !== 8'(trans)) begin
      n_fail++;
      $display("FAIL %s_toggle_count: got %0d expected %0d", name, wave_c[n-1], trans);
    end

    settled = 1'b1;
    for (int i = busy_len; i < n; i++) if (wave_n[i] !== final_lvl) settled = 1'b0;
    n_tests++;
    if (settled !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_settle: got %0b expected 1", name, settled);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    en       = 1'b1;
    clean_in = 1'b0;
    #2;
    n_tests++;
    if ({noisy_output, busy, toggle_count} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %0h expected 0", {noisy_output, busy, toggle_count});
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_tests++;
      if ({noisy_output, busy, toggle_count} !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_idle_c%0d: got %0h expected 0", i, {noisy_output, busy, toggle_count});
      end
    end
  endtask

  task automatic test_burst();
    do_reset(1'b0);
    tick();
    tick();
    tick();
    clean_in = 1'b1;
    capture(24, -1, 1'b0);
    check_burst("burst", 1'b0, 0, BOUNCE, 1'b1, 24);
    for (int i = 0; i < 24; i++) ref_n[i] = wave_n[i];

    do_reset(1'b0);
    tick();
    tick();
    tick();
    clean_in = 1'b1;
    capture(24, -1, 1'b0);
    check_burst("burst_rerun", 1'b0, 0, BOUNCE, 1'b1, 24);
    for (int i = 0; i < 24; i++) begin
      n_tests++;
      if (wave_n[i] !== ref_n[i]) begin
        n_fail++;
        $display("FAIL determinism_c%0d: got %0b expected %0b", i, wave_n[i], ref_n[i]);
      end
    end
  endtask

  task automatic test_retarget();
    do_reset(1'b0);
    tick();
    clean_in = 1'b1;
    capture(28, 4, 1'b0);
    check_burst("retarget", 1'b0, 5, 5 + BOUNCE, 1'b0, 28);
  endtask

  task automatic test_passthrough();
    logic prev;
    en = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (k % 3 == 0) clean_in = ~clean_in;
      prev = clean_in;
      tick();
      n_tests++;
      if (noisy_output !== prev) begin
        n_fail++;
        $display("FAIL passthrough_noisy_c%0d: got %0b expected %0b", k, noisy_output, prev);
      end
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL passthrough_busy_c%0d: got %0b expected 0", k, busy);
      end
    end
  endtask

  task automatic test_en_rise();
    en       = 1'b0;
    clean_in = 1'b1;
    tick();
    tick();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({busy, noisy_output} !== 2'b01) begin
        n_fail++;
        $display("FAIL en_rise_c%0d: got busy,noisy=%0b expected 01", i, {busy, noisy_output});
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset(1'b0);
    tick();
    clean_in = 1'b1;
    capture(7, -1, 1'b0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_busy_before: got %0b expected 1", busy);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({noisy_output, busy, toggle_count} !== 10'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got %0h expected 0", {noisy_output, busy, toggle_count});
    end
    tick();
    reset_n = 1'b1;
    capture(24, -1, 1'b0);
    check_burst("after_reset", 1'b0, 0, BOUNCE, 1'b1, 24);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    en       = 1'b1;
    clean_in = 1'b0;
    test_reset();
    test_burst();
    test_retarget();
    test_passthrough();
    test_en_rise();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
